demux4_12_seq: RTL and testbench
================================

# demux4_12_seq

Registered 1-to-4 time-division demultiplexer: the receive-side counterpart of the 4:1 12-bit word multiplexer. It accepts a serial stream of 12-bit words, one per frame slot, and steers each word into one of four per-channel holding registers. Each register has its own valid/ready handshake, so a slow consumer backpressures the input stream. It sits between a shared muxed bus and four independent channel consumers.

## Interface
- WIDTH, 12, word width of `d` and `y0`..`y3`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `d`  in  WIDTH  input word.
- `in_valid`  in  1  `d` is valid this cycle.
- `in_sof`  in  1  start-of-frame: this word belongs to slot 0.
- `in_ready`  out  1  block can accept the word this cycle.
- `y0`, `y1`, `y2`, `y3`  out  WIDTH  channel holding registers.
- `y_valid`  out  4  bit i: `yi` holds an unconsumed word.
- `y_ready`  in  4  bit i: channel i consumer takes `yi` this cycle.
- `slot`  out  2  current slot counter, which selects the next target channel.
- `frame_err`  out  1  sticky flag for sof misalignment.

## Operation
- Target channel: `tgt = in_sof ? 0 : slot`.
- `in_ready = !y_valid[tgt] || y_ready[tgt]`. This is combinational and has pass-through on drain.
- Accept: `in_valid && in_ready` on a rising edge. On accept:
  - `y[tgt] <= d`.
  - `y_valid[tgt] <= 1`.
  - `slot <= tgt + 1` (mod 4, so 3 wraps to 0).
- sof on accept with `slot != 0`:
  - word is written to channel 0;
  - `slot <= 1`;
  - `frame_err <= 1`.
- sof with `slot == 0`: normal, no error.
- `frame_err` stays set until reset.
- Drain: `y_valid[i] && y_ready[i]` clears `y_valid[i]`, unless the same channel is loaded that edge.
- Simultaneous drain and load on the same channel: the load wins, `y_valid` stays 1 and `yi` takes the new word.
- `yi` is stable while `y_valid[i] = 1` and no load targets channel i.
- No accept (`in_valid` low, or `in_ready` low): `slot` and the channel registers are unchanged. Input words are never dropped or overwritten.
- Drains on different channels are independent and may coincide with a load to another channel.

## Timing
- Reset values:
  - `y0`..`y3` = 0;
  - `y_valid` = 4'b0000;
  - `slot` = 0;
  - `frame_err` = 0;
  - `in_ready` = 1, because all channels are empty.
- Latency: a word accepted at edge N appears on `yi` with `y_valid[i] = 1` after edge N.
- Throughput: one word per cycle while the target consumers are ready or empty.
- Backpressure: with the target channel full and its `y_ready` low, `in_ready` is 0 in that same cycle.
- Reset mid-operation: all held words are discarded and everything returns to reset values at the next edge, regardless of `in_valid` or `y_ready`.

## Configuration
- `DEMUX4_SEL_EN` defined:
  - adds input port `sel` [1:0], and `tgt = sel`;
  - the slot counter is removed and `slot` mirrors `sel`;
  - `in_sof` is ignored and `frame_err` is constant 0.
- `DEMUX4_SEL_EN` undefined: slot-counter mode as described above, and no `sel` port.

## Test plan
- After reset, all `y_ready` high, words 12'h000 (sof), 12'h555, 12'hAAA, 12'hFFF on consecutive cycles -> `y0`..`y3` = 000/555/AAA/FFF, each valid one cycle after its accept, `slot` back to 0, `frame_err` = 0.
- All `y_ready` low, stream of 5 words -> 4 accepted, then `in_ready` = 0 with `slot` = 0 and `y0` unchanged. Raise `y_ready[0]` -> 5th word loads `y0` in that cycle, and `y_valid[0]` stays 1.
- Two words (12'h123, 12'h456) then sof with 12'h789 -> `y0` = 789, `slot` = 1, `frame_err` = 1 and stays 1 through 10 more correct frames.
- Channel 2 full with `y_ready[2]` = 0, `slot` = 2, `in_valid` high -> no accept for 3 cycles, then pulse `y_ready[2]` -> accept in that cycle and `y2` updates at the next edge.
- Reset asserted while channels 1 and 3 are valid and `in_valid` is high -> next edge: `y_valid` = 0, all `y` = 0, `slot` = 0, `frame_err` = 0.
- With `DEMUX4_SEL_EN`: `sel` = 3, 1, 3 with words 12'hA01, 12'hB02, 12'hC03 and all consumers ready -> `y3` = A01 then C03, `y1` = B02, and `frame_err` stays 0.

Source files
------------

// File: rtl/demux4_12_seq_if.sv
// Bus bundle for demux4_12_seq: muxed input word stream plus four channel outputs.
// With DEMUX4_SEL_EN defined an explicit slot select input `sel` is added.
interface demux4_12_seq_if #(parameter int WIDTH = 12);
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [3:0]       y_valid;
    logic [3:0]       y_ready;
    logic [1:0]       slot;
    logic             frame_err;
`ifdef DEMUX4_SEL_EN
    logic [1:0]       sel;
`endif

    modport master (
`ifdef DEMUX4_SEL_EN
        output sel,
`endif
        output d, in_valid, in_sof, y_ready,
        input  in_ready, y0, y1, y2, y3, y_valid, slot, frame_err
    );

    modport slave (
`ifdef DEMUX4_SEL_EN
        input  sel,
`endif
        input  d, in_valid, in_sof, y_ready,
        output in_ready, y0, y1, y2, y3, y_valid, slot, frame_err
    );
endinterface

// File: rtl/demux4_12_seq.sv
// Registered 1-to-4 time-division demultiplexer with per-channel valid/ready holding registers.
// Optional feature macro: DEMUX4_SEL_EN (explicit `sel` input replaces the slot counter).
module demux4_12_seq #(
    parameter int WIDTH = 12
) (
    input logic             clk,
    input logic             reset,
    demux4_12_seq_if.slave  bus
);

    logic [WIDTH-1:0] y_reg [4];
    logic [3:0]       valid_reg;
    logic [1:0]       tgt;
    logic             accept;
    logic [3:0]       load_mask;

`ifdef DEMUX4_SEL_EN
    logic unused_sof;

    assign unused_sof    = bus.in_sof;
    assign tgt           = bus.sel;
    assign bus.slot      = bus.sel;
    assign bus.frame_err = 1'b0;
`else
    logic [1:0] slot_reg;
    logic       err_reg;

    // A start-of-frame always forces the word into channel 0 and realigns the counter.
    assign tgt = bus.in_sof ? 2'd0 : slot_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg <= 2'd0;
            err_reg  <= 1'b0;
        end else if (accept) begin
            slot_reg <= tgt + 2'd1;
            if (bus.in_sof && (slot_reg != 2'd0)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.slot      = slot_reg;
    assign bus.frame_err = err_reg;
`endif

    // A full target channel still accepts when its consumer drains it on the same edge.
    assign bus.in_ready = !valid_reg[tgt] || bus.y_ready[tgt];
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_mask    = 4'(accept) << tgt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                y_reg[i] <= '0;
            end
            valid_reg <= 4'b0000;
        end else begin
            valid_reg <= (valid_reg & ~bus.y_ready) | load_mask;
            if (accept) begin
                y_reg[tgt] <= bus.d;
            end
        end
    end

    assign bus.y0      = y_reg[0];
    assign bus.y1      = y_reg[1];
    assign bus.y2      = y_reg[2];
    assign bus.y3      = y_reg[3];
    assign bus.y_valid = valid_reg;

endmodule

// File: tb/tb_demux4_12_seq.sv
// Scoreboard bench for demux4_12_seq: the driver pushes accepted words into per-channel
// queues, the negedge monitor pops them as consumers take them and compares everything.
module tb_demux4_12_seq;

    logic clk;
    logic reset;
    logic started;
    int   n_checks;
    int   n_fails;

    logic [11:0] exp_q [4][$];
    logic [1:0]  m_slot;
    logic        m_err;
    logic [11:0] y_arr [4];

    demux4_12_seq_if #(.WIDTH(12)) bus ();

    demux4_12_seq #(.WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always_comb begin
        y_arr[0] = bus.y0;
        y_arr[1] = bus.y1;
        y_arr[2] = bus.y2;
        y_arr[3] = bus.y3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] cur_sel();
`ifdef DEMUX4_SEL_EN
        return bus.sel;
`else
        return 2'd0;
`endif
    endfunction

    // Channel a word would go to under the current inputs and the model's slot count.
    function automatic logic [1:0] tgt_of(logic sof);
`ifdef DEMUX4_SEL_EN
        return bus.sel;
`else
        return sof ? 2'd0 : m_slot;
`endif
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances on the edge using only the driven inputs.
    task automatic apply_stimulus(logic rst, logic v, logic sof, logic [11:0] word,
                                  logic [3:0] yr, logic [1:0] sl);
        logic [1:0] t;
        reset        = rst;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.d        = word;
        bus.y_ready  = yr;
`ifdef DEMUX4_SEL_EN
        bus.sel      = sl;
`endif
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) exp_q[i].delete();
            m_slot = 2'd0;
            m_err  = 1'b0;
        end else begin
            t = tgt_of(sof);
            if (v && exp_q[t].size() == 0) begin
                exp_q[t].push_back(word);
`ifndef DEMUX4_SEL_EN
                if (sof && m_slot != 2'd0) m_err = 1'b1;
`endif
                m_slot = t + 2'd1;
            end
        end
        #1;
    endtask

    task automatic check_output(string tag);
        check({tag, " y0"}, 16'(bus.y0), 16'h000);
        check({tag, " y1"}, 16'(bus.y1), 16'h000);
        check({tag, " y2"}, 16'(bus.y2), 16'h000);
        check({tag, " y3"}, 16'(bus.y3), 16'h000);
        check({tag, " y_valid"}, 16'(bus.y_valid), 16'h0);
        check({tag, " frame_err"}, 16'(bus.frame_err), 16'h0);
        check({tag, " in_ready"}, 16'(bus.in_ready), 16'h1);
    endtask

    // Monitor: compares handshake/status against the model and retires consumed words.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                logic [1:0] t;
                t = tgt_of(bus.in_sof);
                check("in_ready", 16'(bus.in_ready),
                      16'((exp_q[t].size() == 0) || bus.y_ready[t]));
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("y_valid[%0d]", i), 16'(bus.y_valid[i]),
                          16'(exp_q[i].size() != 0));
                    if (exp_q[i].size() != 0) begin
                        check($sformatf("y%0d", i), 16'(y_arr[i]), 16'(exp_q[i][0]));
                        if (bus.y_ready[i]) void'(exp_q[i].pop_front());
                    end
                end
`ifdef DEMUX4_SEL_EN
                check("slot", 16'(bus.slot), 16'(bus.sel));
`else
                check("slot", 16'(bus.slot), 16'(m_slot));
`endif
                check("frame_err", 16'(bus.frame_err), 16'(m_err));
            end
        end
    end

    initial begin
        logic       v, sof, rst;
        logic [1:0] sl;
        n_checks = 0;
        n_fails  = 0;
        started  = 1'b0;
        m_slot   = 2'd0;
        m_err    = 1'b0;
        bus.d = '0; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.y_ready = 4'h0;
`ifdef DEMUX4_SEL_EN
        bus.sel = 2'd0;
`endif
        reset = 1'b1;

        apply_stimulus(1, 0, 0, 12'h000, 4'hF, 2'd0);
        started = 1'b1;
        check_output("reset");
        check("reset slot", 16'(bus.slot), 16'h0);

        // Basic frame with all consumers ready.
        apply_stimulus(0, 1, 1, 12'h000, 4'hF, 2'd0);
        apply_stimulus(0, 1, 0, 12'h555, 4'hF, 2'd1);
        apply_stimulus(0, 1, 0, 12'hAAA, 4'hF, 2'd2);
        apply_stimulus(0, 1, 0, 12'hFFF, 4'hF, 2'd3);
        apply_stimulus(0, 0, 0, 12'h000, 4'hF, 2'd0);

        // Backpressure with every consumer stalled, then release channel 0.
        for (int i = 0; i < 5; i++)
            apply_stimulus(0, 1, 0, 12'h100 + 12'(i), 4'h0, 2'(i));
        apply_stimulus(0, 1, 0, 12'h104, 4'h1, 2'd0);
        apply_stimulus(0, 0, 0, 12'h000, 4'hF, 2'd0);
        apply_stimulus(0, 0, 0, 12'h000, 4'hF, 2'd0);

        // Misaligned start-of-frame, then ten clean frames.
        apply_stimulus(0, 1, 0, 12'h123, 4'hF, 2'd1);
        apply_stimulus(0, 1, 0, 12'h456, 4'hF, 2'd2);
        apply_stimulus(0, 1, 1, 12'h789, 4'hF, 2'd0);
        for (int i = 0; i < 43; i++)
            apply_stimulus(0, 1, (m_slot == 2'd0), 12'($urandom), 4'hF, 2'(i));

        // Channel 2 full and stalled while the counter points at it.
        apply_stimulus(1, 0, 0, 12'h000, 4'hF, 2'd0);
        for (int i = 0; i < 6; i++)
            apply_stimulus(0, 1, (i == 0), 12'h200 + 12'(i), 4'b1011, 2'(i));
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1, 0, 12'h2AB, 4'b1011, 2'd2);
        apply_stimulus(0, 1, 0, 12'h2AB, 4'b1111, 2'd2);
        apply_stimulus(0, 0, 0, 12'h000, 4'b1011, 2'd0);
        apply_stimulus(0, 0, 0, 12'h000, 4'hF, 2'd0);

        // Reset while channels hold words and a word is offered.
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 1, (i == 0), 12'h300 + 12'(i), 4'h0, 2'(i));
        apply_stimulus(1, 1, 0, 12'h3FF, 4'h0, 2'd0);
        check_output("mid reset");

`ifdef DEMUX4_SEL_EN
        apply_stimulus(0, 1, 0, 12'hA01, 4'hF, 2'd3);
        apply_stimulus(0, 1, 0, 12'hB02, 4'hF, 2'd1);
        apply_stimulus(0, 1, 0, 12'hC03, 4'hF, 2'd3);
        apply_stimulus(0, 0, 0, 12'h000, 4'hF, 2'd0);
`endif

        // Randomized traffic with occasional misaligned sof and rare resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            v   = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 9) == 0) || ((m_slot == 2'd0) && $urandom_range(0, 1) == 1);
            sl  = 2'($urandom_range(0, 3));
            apply_stimulus(rst, v, sof, 12'($urandom), 4'($urandom), sl);
        end
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 0, 0, 12'h000, 4'hF, cur_sel());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
